// File: rtl/branch_pred_ctrl_pkg.sv
// Shared encodings for the branch predicate controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_pred_ctrl_pkg;

  localparam int STK_DEPTH_DEF = 1024;
  localparam int MAX_NEST_DEF  = 511;
  localparam int NEST_W_DEF    = 10;

  // Control op encodings; codes 5-7 are reserved and behave as NOP.
  typedef logic [2:0] op_code_t;
  localparam op_code_t OP_NOP   = 3'd0;
  localparam op_code_t OP_IF    = 3'd1;
  localparam op_code_t OP_ELIF  = 3'd2;
  localparam op_code_t OP_ELSE  = 3'd3;
  localparam op_code_t OP_ENDIF = 3'd4;

  // IF needs a second cycle to push the old taken flag, ENDIF a second pop.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUSH2 = 2'd1,
    ST_POP2  = 2'd2
  } state_t;

endpackage

// File: rtl/branch_pred_ctrl_if.sv
// Op handshake between the PE instruction decoder and the predicate controller.
// Latency: n/a (wires only).
// Backpressure: op_ready low means the op on the bus is not consumed.
interface branch_pred_ctrl_if;
  import branch_pred_ctrl_pkg::*;

  logic     op_valid;
  op_code_t op;
  logic     cond;
  logic     op_ready;

  modport master (output op_valid, output op, output cond, input op_ready);
  modport slave  (input op_valid, input op, input cond, output op_ready);

endinterface

// File: rtl/branch_pred_ctrl.sv
// Structured IF/ELIF/ELSE/ENDIF decoder producing the PE execution predicate via a 1-bit branch stack.
// Latency: pred updates one cycle after accept; IF and ENDIF occupy two cycles, ELIF/ELSE/NOP one.
// Backpressure: op_ready drops for the second cycle of IF/ENDIF; en low freezes everything.
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int STK_DEPTH = STK_DEPTH_DEF,
  parameter int MAX_NEST  = MAX_NEST_DEF,
  parameter int NEST_W    = NEST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  branch_pred_ctrl_if.slave bus,
  output logic              pred,
  output logic [NEST_W-1:0] nest,
  output logic              err_ovf,
  output logic              err_unf,
  input  logic              clr_err,
  output logic              stk_en,
  output logic              stk_push,
  output logic              stk_pop,
  output logic              stk_din,
  input  logic              stk_dout
);

  // Each level costs two entries, so never nest deeper than the stack can hold.
  localparam int NEST_CAP = (MAX_NEST < STK_DEPTH / 2) ? MAX_NEST : (STK_DEPTH / 2 - 1);
  localparam logic [NEST_W-1:0] NEST_MAX = NEST_W'(NEST_CAP);

  state_t            state, state_nxt;
  logic              par, par_nxt;
  logic              taken, taken_nxt;
  logic              hold_taken, hold_taken_nxt;
  logic              pred_nxt;
  logic [NEST_W-1:0] nest_nxt;
  logic              err_ovf_nxt, err_unf_nxt;

  assign bus.op_ready = (state == ST_IDLE);
  assign stk_en       = en;

  // Next-state, register updates and stack strobes; en low leaves everything as is.
  always_comb begin
    state_nxt      = state;
    pred_nxt       = pred;
    par_nxt        = par;
    taken_nxt      = taken;
    hold_taken_nxt = hold_taken;
    nest_nxt       = nest;
    err_ovf_nxt    = err_ovf;
    err_unf_nxt    = err_unf;
    stk_push       = 1'b0;
    stk_pop        = 1'b0;
    stk_din        = 1'b0;

    if (en) begin
      // Cleared first so that an error raised in the same cycle wins.
      if (clr_err) begin
        err_ovf_nxt = 1'b0;
        err_unf_nxt = 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (bus.op_valid) begin
            case (bus.op)
              OP_IF: begin
                if (nest == NEST_MAX) begin
                  err_ovf_nxt = 1'b1;
                end else begin
                  stk_push       = 1'b1;
                  stk_din        = par;
                  par_nxt        = pred;
                  pred_nxt       = pred & bus.cond;
                  hold_taken_nxt = taken;
                  state_nxt      = ST_PUSH2;
                end
              end
              OP_ELIF: begin
                if (nest == '0) begin
                  err_unf_nxt = 1'b1;
                end else begin
                  pred_nxt  = par & ~taken & bus.cond;
                  taken_nxt = taken | (par & bus.cond);
                end
              end
              OP_ELSE: begin
                if (nest == '0) begin
                  err_unf_nxt = 1'b1;
                end else begin
                  pred_nxt  = par & ~taken;
                  taken_nxt = par;
                end
              end
              OP_ENDIF: begin
                if (nest == '0) begin
                  err_unf_nxt = 1'b1;
                end else begin
                  pred_nxt  = par;
                  taken_nxt = stk_dout;
                  stk_pop   = 1'b1;
                  state_nxt = ST_POP2;
                end
              end
              default: ;
            endcase
          end
        end
        ST_PUSH2: begin
          // pred already equals old_pred & cond, i.e. par & cond of the new level.
          stk_push  = 1'b1;
          stk_din   = hold_taken;
          taken_nxt = pred;
          nest_nxt  = nest + NEST_W'(1);
          state_nxt = ST_IDLE;
        end
        ST_POP2: begin
          stk_pop   = 1'b1;
          par_nxt   = stk_dout;
          nest_nxt  = nest - NEST_W'(1);
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Predicate, nesting and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred       <= 1'b1;
      par        <= 1'b1;
      taken      <= 1'b0;
      hold_taken <= 1'b0;
      nest       <= '0;
      err_ovf    <= 1'b0;
      err_unf    <= 1'b0;
    end else begin
      pred       <= pred_nxt;
      par        <= par_nxt;
      taken      <= taken_nxt;
      hold_taken <= hold_taken_nxt;
      nest       <= nest_nxt;
      err_ovf    <= err_ovf_nxt;
      err_unf    <= err_unf_nxt;
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl with a frame-stack model and a behavioural branch stack.
// Latency: ops are issued one at a time and the bench waits for op_ready before the next.
// Backpressure: en is dropped mid-IF to check the sequence stalls and resumes.
module tb_branch_pred_ctrl;
  import branch_pred_ctrl_pkg::*;

  localparam int MAXN = 3;
  localparam int NW   = 10;

  logic          clk, rst, en, clr_err;
  logic          pred, err_ovf, err_unf;
  logic [NW-1:0] nest;
  logic          stk_en, stk_push, stk_pop, stk_din, stk_dout;

  branch_pred_ctrl_if bif();

  branch_pred_ctrl #(.STK_DEPTH(8), .MAX_NEST(MAXN), .NEST_W(NW)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bif),
    .pred(pred), .nest(nest), .err_ovf(err_ovf), .err_unf(err_unf), .clr_err(clr_err),
    .stk_en(stk_en), .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Behavioural branch stack: combinational top, push/pop on the clock edge.
  logic       stk_mem [0:15];
  int         sp;
  logic [3:0] top_idx;
  logic       push_log [$];
  int         pop_cnt;

  assign top_idx  = 4'(sp - 1);
  assign stk_dout = (sp > 0) ? stk_mem[top_idx] : 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= 0;
    end else if (stk_en) begin
      if (stk_push) begin
        stk_mem[4'(sp)] <= stk_din;
        sp <= sp + 1;
        push_log.push_back(stk_din);
      end
      if (stk_pop) begin
        sp <= sp - 1;
        pop_cnt++;
      end
    end
  end

  // Model: one {parent, taken} frame per open IF, updated once per completed op.
  logic       m_pred, m_par, m_taken, m_ovf, m_unf;
  int         m_nest;
  logic [1:0] frames [$];
  logic       exp_push [$];
  int         exp_pops;
  logic       model_ok = 1'b0;

  task automatic model_reset();
    m_pred = 1'b1; m_par = 1'b1; m_taken = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; m_nest = 0;
    frames.delete();
  endtask

  task automatic model_step(input logic [2:0] o, input logic c, input logic clr);
    logic [1:0] f;
    logic       arm;
    exp_push.delete();
    exp_pops = 0;
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (o == OP_IF) begin
      if (m_nest == MAXN) m_ovf = 1'b1;
      else begin
        exp_push.push_back(m_par);
        exp_push.push_back(m_taken);
        frames.push_back({m_par, m_taken});
        m_par   = m_pred;
        m_pred  = m_pred & c;
        m_taken = m_pred;
        m_nest++;
      end
    end else if (o == OP_ELIF || o == OP_ELSE || o == OP_ENDIF) begin
      if (m_nest == 0) m_unf = 1'b1;
      else if (o == OP_ELIF) begin
        // An arm fires only if the enclosing block runs, no earlier arm fired, and cond holds.
        arm     = m_par && !m_taken && c;
        m_taken = m_taken || (m_par && c);
        m_pred  = arm;
      end else if (o == OP_ELSE) begin
        m_pred  = m_par && !m_taken;
        m_taken = m_par;
      end else begin
        m_pred = m_par;
        f = frames.pop_back();
        m_par   = f[1];
        m_taken = f[0];
        m_nest--;
        exp_pops = 2;
      end
    end
  endtask

  task automatic check_stack(input string nm);
    chk({nm, "_push_cnt"}, push_log.size(), exp_push.size());
    for (int i = 0; i < exp_push.size(); i++)
      if (i < push_log.size()) chk({nm, "_push_din"}, push_log[i], exp_push[i]);
    chk({nm, "_pop_cnt"}, pop_cnt, exp_pops);
  endtask

  // Issue one op (called just after a rising edge) and wait for it to complete.
  task automatic do_op(input logic [2:0] o, input logic c, input logic clr);
    int n;
    model_ok = 1'b0;
    push_log.delete();
    pop_cnt = 0;
    bif.op_valid = 1'b1; bif.op = o; bif.cond = c; clr_err = clr;
    @(posedge clk); #1;
    bif.op_valid = 1'b0; bif.op = OP_NOP; bif.cond = 1'b0; clr_err = 1'b0;
    n = 0;
    while (!bif.op_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("op_ready_timeout", bif.op_ready, 1);
    model_step(o, c, clr);
    check_stack("op");
    model_ok = 1'b1;
  endtask

  // Every settled cycle: outputs must match the model.
  always @(negedge clk) begin
    if (rst) chk("push_pop_excl", stk_push & stk_pop, 0);
    if (rst && model_ok) begin
      chk("mon_pred", pred, m_pred);
      chk("mon_nest", nest, m_nest);
      chk("mon_err_ovf", err_ovf, m_ovf);
      chk("mon_err_unf", err_unf, m_unf);
      chk("mon_op_ready", bif.op_ready, 1);
      chk("mon_idle_push", stk_push, 0);
      chk("mon_idle_pop", stk_pop, 0);
      chk("mon_stk_depth", sp, 2 * m_nest);
      chk("mon_stk_en", stk_en, en);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 1'b1; clr_err = 1'b0;
    bif.op_valid = 1'b0; bif.op = OP_NOP; bif.cond = 1'b0;
    pop_cnt = 0;
    model_reset();

    @(negedge clk);
    chk("rst_pred", pred, 1);
    chk("rst_nest", nest, 0);
    chk("rst_op_ready", bif.op_ready, 1);
    chk("rst_push", stk_push, 0);
    chk("rst_pop", stk_pop, 0);
    chk("rst_din", stk_din, 0);
    chk("rst_errs", {err_ovf, err_unf}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_ok = 1'b1;

    // NOP x3 and a reserved code: nothing moves.
    repeat (3) do_op(OP_NOP, 1'b1, 1'b0);
    do_op(3'd6, 1'b1, 1'b0);
    chk("nop_pred", pred, 1);
    chk("nop_nest", nest, 0);

    // IF 0; ELSE; ENDIF
    do_op(OP_IF, 1'b0, 1'b0);
    chk("if0_pred", pred, 0);
    chk("if0_nest", nest, 1);
    chk("if0_push_cnt", push_log.size(), 2);
    if (push_log.size() == 2) begin
      chk("if0_din0", push_log[0], 1);
      chk("if0_din1", push_log[1], 0);
    end
    do_op(OP_ELSE, 1'b0, 1'b0);
    chk("else_pred", pred, 1);
    do_op(OP_ENDIF, 1'b0, 1'b0);
    chk("endif_pred", pred, 1);
    chk("endif_nest", nest, 0);
    chk("endif_pops", pop_cnt, 2);

    // IF 1; IF 0; ELIF 1; ENDIF; ENDIF
    do_op(OP_IF, 1'b1, 1'b0);   chk("n_if1_pred", pred, 1);
    do_op(OP_IF, 1'b0, 1'b0);   chk("n_if0_pred", pred, 0);
    chk("n_peak_nest", nest, 2);
    do_op(OP_ELIF, 1'b1, 1'b0); chk("n_elif_pred", pred, 1);
    do_op(OP_ENDIF, 1'b0, 1'b0); chk("n_endif1_pred", pred, 1);
    do_op(OP_ENDIF, 1'b0, 1'b0); chk("n_endif2_pred", pred, 1);
    chk("n_par_restored", dut.par, 1);
    chk("n_taken_restored", dut.taken, 0);

    // IF 0; IF 1 nested in a false arm; ELSE stays off
    do_op(OP_IF, 1'b0, 1'b0);
    do_op(OP_IF, 1'b1, 1'b0);   chk("f_inner_if_pred", pred, 0);
    do_op(OP_ELSE, 1'b0, 1'b0); chk("f_inner_else_pred", pred, 0);
    do_op(OP_ENDIF, 1'b0, 1'b0);
    do_op(OP_ENDIF, 1'b0, 1'b0);

    // Underflow, then clear; clear colliding with a new error
    do_op(OP_ENDIF, 1'b0, 1'b0);
    chk("unf_flag", err_unf, 1);
    chk("unf_no_pop", pop_cnt, 0);
    chk("unf_pred", pred, 1);
    do_op(OP_NOP, 1'b0, 1'b1);
    chk("unf_cleared", err_unf, 0);
    do_op(OP_ELSE, 1'b0, 1'b1);
    chk("clr_vs_err", err_unf, 1);
    do_op(OP_NOP, 1'b0, 1'b1);

    // Overflow at MAX_NEST=3
    repeat (4) do_op(OP_IF, 1'b1, 1'b0);
    chk("ovf_flag", err_ovf, 1);
    chk("ovf_nest", nest, 3);
    chk("ovf_no_push", push_log.size(), 0);
    repeat (3) do_op(OP_ENDIF, 1'b0, 1'b0);
    do_op(OP_NOP, 1'b0, 1'b1);

    // en dropped during PUSH2 for 5 cycles
    model_ok = 1'b0;
    push_log.delete();
    pop_cnt = 0;
    bif.op_valid = 1'b1; bif.op = OP_IF; bif.cond = 1'b1;
    @(posedge clk); #1;
    bif.op_valid = 1'b0; bif.op = OP_NOP;
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_push", stk_push, 0);
      chk("stall_ready", bif.op_ready, 0);
      chk("stall_nest", nest, 0);
      chk("stall_stk_en", stk_en, 0);
    end
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    chk("stall_done_ready", bif.op_ready, 1);
    chk("stall_done_nest", nest, 1);
    model_step(OP_IF, 1'b1, 1'b0);
    check_stack("stall");
    model_ok = 1'b1;
    do_op(OP_ENDIF, 1'b0, 1'b0);

    // Reset in the middle of an IF sequence
    do_op(OP_IF, 1'b0, 1'b0);
    model_ok = 1'b0;
    bif.op_valid = 1'b1; bif.op = OP_IF; bif.cond = 1'b1;
    @(posedge clk); #1;
    bif.op_valid = 1'b0; bif.op = OP_NOP;
    rst = 1'b0;
    #1;
    chk("rstmid_pred", pred, 1);
    chk("rstmid_nest", nest, 0);
    chk("rstmid_ready", bif.op_ready, 1);
    chk("rstmid_push", stk_push, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    model_ok = 1'b1;
    do_op(OP_IF, 1'b1, 1'b0);
    do_op(OP_ENDIF, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
